// File: rtl/axi_read_slave_mem.sv
// Memory-backed AXI read-channel slave (AR/R only): FIXED/INCR/WRAP bursts, narrow
// sizes, programmable first-beat latency, SLVERR/DECERR reporting and a backdoor write port.
module axi_read_slave_mem #(
    parameter int                ADDR_W    = 32,
    parameter int                LEN_W     = 4,
    parameter int                SIZE_W    = 3,
    parameter int                DATA_W    = 32,
    parameter int                MEM_DEPTH = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                LATENCY   = 0
) (
    input  logic                         G_clk,
    input  logic                         G_reset,
    input  logic [ADDR_W-1:0]            ARADDR,
    input  logic [LEN_W-1:0]             ARLEN,
    input  logic [SIZE_W-1:0]            ARSIZE,
    input  logic [1:0]                   ARBURST,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic                         RVALID,
    input  logic                         RREADY,
    output logic [DATA_W-1:0]            RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RLAST,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DATA_W-1:0]            mem_wdata,
    output logic                         busy
);

    localparam int BYTES  = DATA_W / 8;
    localparam int BSH    = $clog2(BYTES);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int REG_SH = IDX_W + BSH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic                err_q, err_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic [3:0]          lat_q, lat_d;
    logic                arready_q, arready_d;
    logic                rvalid_q, rvalid_d;
    logic                rlast_q, rlast_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;

    logic                ar_err;
    logic                wrap_len_ok;
    logic [ADDR_W-1:0]   ar_step;
    logic                in_idle;
    logic [ADDR_W-1:0]   src_addr;
    logic [LEN_W-1:0]    src_len;
    logic [SIZE_W-1:0]   src_size;
    logic [1:0]          src_burst;
    logic                src_err;
    logic [ADDR_W-1:0]   src_step;
    logic [ADDR_W-1:0]   wrap_span;
    logic [ADDR_W-1:0]   wrap_mask;
    logic [ADDR_W-1:0]   next_addr;
    logic                in_range;
    logic [IDX_W-1:0]    src_idx;
    logic [DATA_W-1:0]   ld_rdata;
    logic [1:0]          ld_rresp;
    logic                ld_rlast;
    logic                beat_load;

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;
    assign busy    = busy_q;

    // Backdoor port; a beat loaded on the same edge sees the pre-write word.
    always_ff @(posedge G_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        ar_step     = ADDR_W'(1) << ARSIZE;
        wrap_len_ok = (ARLEN != '0) && ((ARLEN & (ARLEN + LEN_W'(1))) == '0);
        ar_err      = (ARBURST == 2'b11)
                   || (ARSIZE > SIZE_W'(BSH))
                   || ((ARBURST == 2'b10) && !wrap_len_ok)
                   || ((ARBURST == 2'b10) && ((ARADDR & (ar_step - ADDR_W'(1))) != '0));
    end

    // With zero latency the first beat is loaded straight from the AR inputs.
    always_comb begin
        in_idle   = (state_q == S_IDLE);
        src_addr  = in_idle ? ARADDR  : addr_q;
        src_len   = in_idle ? ARLEN   : len_q;
        src_size  = in_idle ? ARSIZE  : size_q;
        src_burst = in_idle ? ARBURST : burst_q;
        src_err   = in_idle ? ar_err  : err_q;

        src_step  = ADDR_W'(1) << src_size;
        wrap_span = (ADDR_W'(src_len) + ADDR_W'(1)) << src_size;
        wrap_mask = wrap_span - ADDR_W'(1);
        case (src_burst)
            2'b00:   next_addr = src_addr;
            2'b10:   next_addr = (src_addr & ~wrap_mask) | ((src_addr + src_step) & wrap_mask);
            default: next_addr = src_addr + src_step;
        endcase

        // BASE_ADDR is aligned to the window size, so matching upper bits is the range test.
        in_range = ((src_addr >> REG_SH) == (BASE_ADDR >> REG_SH));
        src_idx  = src_addr[REG_SH-1:BSH];
        ld_rdata = (src_err || !in_range) ? '0 : mem[src_idx];
        ld_rresp = src_err ? 2'b10 : (in_range ? 2'b00 : 2'b11);
        ld_rlast = (beat_q == src_len);
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        err_d     = err_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        beat_load = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ARVALID && arready_q) begin
                    len_d     = ARLEN;
                    size_d    = ARSIZE;
                    burst_d   = ARBURST;
                    err_d     = ar_err;
                    arready_d = 1'b0;
                    busy_d    = 1'b1;
                    if (LATENCY == 0) begin
                        beat_load = 1'b1;
                        state_d   = S_BURST;
                    end else begin
                        addr_d  = ARADDR;
                        lat_d   = 4'(LATENCY - 1);
                        state_d = S_WAIT;
                    end
                end else begin
                    arready_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (lat_q == 4'd0) begin
                    beat_load = 1'b1;
                    state_d   = S_BURST;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_BURST: begin
                if (rvalid_q && RREADY) begin
                    if (rlast_q) begin
                        state_d   = S_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        busy_d    = 1'b0;
                        beat_d    = '0;
                    end else begin
                        beat_load = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (beat_load) begin
            rvalid_d = 1'b1;
            rdata_d  = ld_rdata;
            rresp_d  = ld_rresp;
            rlast_d  = ld_rlast;
            addr_d   = next_addr;
            beat_d   = beat_q + LEN_W'(1);
        end
    end

    always_ff @(posedge G_clk or negedge G_reset) begin
        if (!G_reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            beat_q    <= '0;
            lat_q     <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_axi_read_slave_mem.sv
// Bench for axi_read_slave_mem: two instances (base 0 / no latency, base 0x10000 / latency 3)
// driven with directed and random bursts, checked against an arithmetic burst model.
module tb_axi_read_slave_mem;

    localparam logic [31:0] BASE1 = 32'h0001_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n;
    logic [1:0][31:0] araddr;
    logic [1:0][3:0]  arlen;
    logic [1:0][2:0]  arsize;
    logic [1:0][1:0]  arburst;
    logic [1:0]       arvalid;
    logic [1:0]       rready;
    logic [1:0]       mem_we;
    logic [1:0][9:0]  mem_waddr;
    logic [1:0][31:0] mem_wdata;

    logic        arready_o0, arready_o1, rvalid_o0, rvalid_o1, rlast_o0, rlast_o1, busy_o0, busy_o1;
    logic [31:0] rdata_o0, rdata_o1;
    logic [1:0]  rresp_o0, rresp_o1;

    logic [1:0]       arready_w, rvalid_w, rlast_w, busy_w;
    logic [1:0][31:0] rdata_w;
    logic [1:0][1:0]  rresp_w;
    assign arready_w = {arready_o1, arready_o0};
    assign rvalid_w  = {rvalid_o1, rvalid_o0};
    assign rlast_w   = {rlast_o1, rlast_o0};
    assign busy_w    = {busy_o1, busy_o0};
    assign rdata_w   = {rdata_o1, rdata_o0};
    assign rresp_w   = {rresp_o1, rresp_o0};

    axi_read_slave_mem #(.BASE_ADDR(32'h0), .LATENCY(0)) dut0 (
        .G_clk(clk), .G_reset(rst_n[0]),
        .ARADDR(araddr[0]), .ARLEN(arlen[0]), .ARSIZE(arsize[0]), .ARBURST(arburst[0]),
        .ARVALID(arvalid[0]), .ARREADY(arready_o0),
        .RVALID(rvalid_o0), .RREADY(rready[0]), .RDATA(rdata_o0), .RRESP(rresp_o0), .RLAST(rlast_o0),
        .mem_we(mem_we[0]), .mem_waddr(mem_waddr[0]), .mem_wdata(mem_wdata[0]), .busy(busy_o0)
    );

    axi_read_slave_mem #(.BASE_ADDR(BASE1), .LATENCY(3)) dut1 (
        .G_clk(clk), .G_reset(rst_n[1]),
        .ARADDR(araddr[1]), .ARLEN(arlen[1]), .ARSIZE(arsize[1]), .ARBURST(arburst[1]),
        .ARVALID(arvalid[1]), .ARREADY(arready_o1),
        .RVALID(rvalid_o1), .RREADY(rready[1]), .RDATA(rdata_o1), .RRESP(rresp_o1), .RLAST(rlast_o1),
        .mem_we(mem_we[1]), .mem_waddr(mem_waddr[1]), .mem_wdata(mem_wdata[1]), .busy(busy_o1)
    );

    logic [31:0] model [2][1024];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? 32'h0 : BASE1;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected beat i of a burst, from the burst rules in plain arithmetic.
    task automatic expect_beat(input int d, input logic [31:0] start, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int i,
                               output logic [31:0] data, output logic [1:0] resp, output logic last);
        longint nb, s, a, bound, lower, base;
        bit err, len_ok;
        nb     = longint'(1) << size;
        s      = longint'(start);
        len_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
        err    = (burst == 2'b11) || (nb > 4) || (burst == 2'b10 && !len_ok)
              || (burst == 2'b10 && (s % nb) != 0);
        if (burst == 2'b00) begin
            a = s;
        end else if (burst == 2'b01) begin
            a = (s + i * nb) & 64'hFFFF_FFFF;
        end else begin
            bound = (longint'(len) + 1) * nb;
            lower = s - (s % bound);
            a     = lower + ((s % bound) + i * nb) % bound;
        end
        base = longint'(base_of(d));
        last = (i == int'(len));
        if (err) begin
            data = 32'h0;
            resp = 2'b10;
        end else if (a >= base && a <= base + 4095) begin
            data = model[d][int'((a - base) >> 2)];
            resp = 2'b00;
        end else begin
            data = 32'h0;
            resp = 2'b11;
        end
    endtask

    // Issues one AR on instance d and consumes the whole burst. RREADY comes from pat
    // (LSB first, 1 once exhausted) or randomly when rnd is set.
    task automatic run_burst(input int d, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [31:0] pat, input bit rnd);
        int cyc, beat, pidx, guard;
        logic [31:0] ed;
        logic [1:0]  er;
        logic        el;
        bit          acc;
        araddr[d]  = addr;
        arlen[d]   = len;
        arsize[d]  = size;
        arburst[d] = burst;
        arvalid[d] = 1'b1;
        guard = 0;
        while (!arready_w[d] && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("arready_wait", 64'(arready_w[d]), 64'd1);
        if (!arready_w[d]) begin
            arvalid[d] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        arvalid[d] = 1'b0;
        check("busy_after_ar", 64'(busy_w[d]), 64'd1);
        check("arready_after_ar", 64'(arready_w[d]), 64'd0);
        cyc = 0;
        while (!rvalid_w[d] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("first_beat_latency", 64'(cyc), 64'(lat_of(d)));
        beat = 0;
        pidx = 0;
        guard = 0;
        while (beat <= int'(len) && guard < 200) begin
            expect_beat(d, addr, len, size, burst, beat, ed, er, el);
            check("rvalid", 64'(rvalid_w[d]), 64'd1);
            check("rdata", 64'(rdata_w[d]), 64'(ed));
            check("rresp", 64'(rresp_w[d]), 64'(er));
            check("rlast", 64'(rlast_w[d]), 64'(el));
            if (rnd) acc = ($urandom_range(0, 3) != 0);
            else     acc = (pidx < 32) ? pat[pidx] : 1'b1;
            rready[d] = acc;
            @(posedge clk); #1;
            pidx++;
            guard++;
            if (acc) beat++;
        end
        rready[d] = 1'b0;
        check("burst_beats", 64'(beat), 64'(int'(len) + 1));
        check("rvalid_after_last", 64'(rvalid_w[d]), 64'd0);
        check("rlast_after_last", 64'(rlast_w[d]), 64'd0);
        check("busy_after_last", 64'(busy_w[d]), 64'd0);
        check("arready_after_last", 64'(arready_w[d]), 64'd1);
        $display("burst dut%0d addr=%08h len=%0d size=%0d type=%0d beats=%0d cycles=%0d",
                 d, addr, len, size, burst, beat, pidx);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  ln;
        logic [2:0]  sz;
        logic [1:0]  bt;
        int          d;
        int          w;
        int          guard;

        rst_n = 2'b00; arvalid = '0; rready = '0; mem_we = '0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; mem_waddr = '0; mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_arready", 64'(arready_w[k]), 64'd0);
            check("rst_rvalid", 64'(rvalid_w[k]), 64'd0);
            check("rst_busy", 64'(busy_w[k]), 64'd0);
            check("rst_rdata", 64'(rdata_w[k]), 64'd0);
            check("rst_rresp", 64'(rresp_w[k]), 64'd0);
            check("rst_rlast", 64'(rlast_w[k]), 64'd0);
        end
        @(negedge clk);
        rst_n = 2'b11;
        @(posedge clk); #1;
        check("arready_after_release0", 64'(arready_w[0]), 64'd1);
        check("arready_after_release1", 64'(arready_w[1]), 64'd1);

        for (int i = 0; i < 1024; i++) begin
            mem_we       = 2'b11;
            mem_waddr[0] = 10'(i);
            mem_waddr[1] = 10'(i);
            mem_wdata[0] = 32'hA000_0000 + 32'(i);
            mem_wdata[1] = 32'hA000_0000 + 32'(i);
            model[0][i]  = 32'hA000_0000 + 32'(i);
            model[1][i]  = 32'hA000_0000 + 32'(i);
            @(posedge clk); #1;
        end
        mem_we = 2'b00;

        run_burst(0, 32'h10, 4'd3, 3'd2, 2'b01, 32'hFFFF_FFFF, 1'b0);
        run_burst(0, 32'h38, 4'd3, 3'd2, 2'b10, 32'hFFFF_FFFF, 1'b0);
        run_burst(0, 32'h08, 4'd2, 3'd2, 2'b00, 32'hFFFF_FFF9, 1'b0);
        run_burst(1, BASE1 + 32'hFF8, 4'd3, 3'd2, 2'b01, 32'hFFFF_FFFF, 1'b0);
        run_burst(0, 32'h0, 4'd0, 3'd2, 2'b11, 32'hFFFF_FFFF, 1'b0);
        run_burst(0, 32'h0, 4'd2, 3'd3, 2'b01, 32'hFFFF_FFFF, 1'b0);
        run_burst(0, 32'h40, 4'd2, 3'd2, 2'b10, 32'hFFFF_FFFF, 1'b0);
        run_burst(0, 32'h42, 4'd3, 3'd2, 2'b10, 32'hFFFF_FFFF, 1'b0);
        run_burst(0, 32'hFFFF_FFF8, 4'd3, 3'd2, 2'b01, 32'hFFFF_FFFF, 1'b0);
        run_burst(0, 32'h101, 4'd15, 3'd0, 2'b01, 32'hFFFF_FFFF, 1'b0);
        run_burst(1, BASE1 + 32'h20, 4'd15, 3'd1, 2'b10, 32'h5555_5555, 1'b0);

        // Reset mid-burst on the latency-3 instance.
        araddr[1] = BASE1 + 32'h10; arlen[1] = 4'd3; arsize[1] = 3'd2; arburst[1] = 2'b01;
        arvalid[1] = 1'b1;
        @(posedge clk); #1;
        arvalid[1] = 1'b0;
        guard = 0;
        while (!rvalid_w[1] && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("rst_test_first_beat", 64'(rvalid_w[1]), 64'd1);
        rready[1] = 1'b1;
        @(posedge clk); #1;
        rready[1] = 1'b0;
        check("rst_test_second_beat", 64'(rdata_w[1]), 64'hA000_0005);
        rst_n[1] = 1'b0;
        #1;
        check("async_rst_rvalid", 64'(rvalid_w[1]), 64'd0);
        check("async_rst_busy", 64'(busy_w[1]), 64'd0);
        check("async_rst_rdata", 64'(rdata_w[1]), 64'd0);
        check("async_rst_rlast", 64'(rlast_w[1]), 64'd0);
        check("async_rst_arready", 64'(arready_w[1]), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n[1] = 1'b1;
        #1;
        check("arready_before_edge", 64'(arready_w[1]), 64'd0);
        @(posedge clk); #1;
        check("arready_one_edge_after", 64'(arready_w[1]), 64'd1);
        for (int k = 0; k < 5; k++) begin
            check("no_stray_rvalid", 64'(rvalid_w[1]), 64'd0);
            check("no_stray_busy", 64'(busy_w[1]), 64'd0);
            @(posedge clk); #1;
        end
        run_burst(1, BASE1 + 32'h20, 4'd3, 3'd2, 2'b01, 32'hFFFF_FFFF, 1'b0);

        for (int n = 0; n < 40; n++) begin
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                w = int'($urandom_range(0, 1023));
                mem_we[d]    = 1'b1;
                mem_waddr[d] = 10'(w);
                mem_wdata[d] = $urandom;
                model[d][w]  = mem_wdata[d];
                @(posedge clk); #1;
                mem_we[d] = 1'b0;
            end
            sz = 3'($urandom_range(0, 3));
            bt = 2'($urandom_range(0, 3));
            ln = 4'($urandom_range(0, 15));
            if (bt == 2'b10 && $urandom_range(0, 1) == 1) ln = 4'((2 << $urandom_range(0, 3)) - 1);
            a = base_of(d) + 32'($urandom_range(0, 4160)) - 32'd32;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            run_burst(d, a, ln, sz, bt, 32'h0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
